// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampling 8N1 UART receiver with byte FIFO and error flags
module uart_rx_fifo #(
   parameter int CLK_HZ = 27000000,
   parameter int BAUD   = 115200,
   parameter int DEPTH  = 8
) (
   input  logic                       sys_clk,
   input  logic                       rst_n,
   input  logic                       uart_rx,
   input  logic                       rx_ready,
   output logic [7:0]                 rx_data,
   output logic                       rx_data_wr,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       frame_err,
   output logic                       overrun,
   input  logic                       err_clr
);

   localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic          sync1;
   logic          rxs;
   logic [TW-1:0] tcnt;
   logic          tick;
   logic [3:0]    sc;
   logic [2:0]    state;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          smp7;
   logic          smp8;
   logic          vote;
   logic          start_det;
   logic          mid;
   logic          push;
   logic          push_ok;
   logic          fe_set;
   logic          ovr_set;
   logic          pop;
   logic          empty;
   logic          full;
   logic [AW:0]   wp;
   logic [AW:0]   rp;
   logic [7:0]    mem [DEPTH];

   // Synchroniser flops reset high so a released reset never looks like a start edge.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= uart_rx;
         rxs   <= sync1;
      end
   end

   assign tick      = (tcnt == TW'(DIV - 1));
   assign vote      = (smp7 & smp8) | (smp7 & rxs) | (smp8 & rxs);
   assign start_det = (state == S_IDLE) && !rxs;
   assign mid       = tick && (sc == 4'd9);
   assign push      = (state == S_STOP) && mid && vote;
   assign fe_set    = (state == S_STOP) && mid && !vote;

   assign empty   = (wp == rp);
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop     = rx_ready && !empty;
   assign push_ok = push && (!full || pop);
   assign ovr_set = push && full && !pop;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt <= '0;
         sc   <= 4'd0;
         smp7 <= 1'b1;
         smp8 <= 1'b1;
      end else begin
         if (start_det || tick) tcnt <= '0;
         else                   tcnt <= tcnt + TW'(1);

         if (start_det)                    sc <= 4'd0;
         else if (tick && state != S_IDLE) sc <= sc + 4'd1;

         if (tick && sc == 4'd7) smp7 <= rxs;
         if (tick && sc == 4'd8) smp8 <= rxs;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         bit_idx <= 3'd0;
         shreg   <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!rxs) state <= S_START;
            end
            S_START: begin
               if (tick) begin
                  if (sc == 4'd9 && vote) begin
                     state <= S_IDLE;
                  end else if (sc == 4'd15) begin
                     state   <= S_DATA;
                     bit_idx <= 3'd0;
                  end
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (sc == 4'd9) shreg <= {vote, shreg[7:1]};
                  if (sc == 4'd15) begin
                     if (bit_idx == 3'd7) state <= S_STOP;
                     else                 bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            // Leave at mid-stop so a following frame can resync on its start edge.
            S_STOP: begin
               if (mid) state <= vote ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
               if (rxs) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push_ok) mem[wp[AW-1:0]] <= shreg;
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wp         <= '0;
         rp         <= '0;
         rx_data    <= 8'd0;
         rx_data_wr <= 1'b0;
      end else begin
         if (push_ok) wp <= wp + (AW + 1)'(1);
         rx_data_wr <= pop;
         if (pop) begin
            rx_data <= mem[rp[AW-1:0]];
            rp      <= rp + (AW + 1)'(1);
         end
      end
   end

   // A set in the same cycle as err_clr wins.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (fe_set)       frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (ovr_set)      overrun <= 1'b1;
         else if (err_clr) overrun <= 1'b0;
      end
   end

   assign fifo_level = wp - rp;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with serial-line frame model
module tb_uart_rx_fifo;

   localparam int DEPTH = 8;
   localparam int BP    = 240;

   logic       sys_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] rx_data;
   logic       rx_data_wr;
   logic [3:0] fifo_level;
   logic       frame_err;
   logic       overrun;

   uart_rx_fifo #(.CLK_HZ(27000000), .BAUD(115200), .DEPTH(DEPTH)) dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .uart_rx    (uart_rx),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .rx_data_wr (rx_data_wr),
      .fifo_level (fifo_level),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .err_clr    (err_clr)
   );

   always #5 sys_clk = ~sys_clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         wr_times[$];
   bit         exp_ovr = 1'b0;
   bit         exp_fe = 1'b0;
   logic [7:0] mon_exp;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Monitor: every delivery strobe is matched against the oldest expected byte.
   always @(negedge sys_clk) begin
      if (rst_n && rx_data_wr) begin
         wr_times.push_back(cyc);
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL rx_byte unexpected: got %02h, required no delivery", rx_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (rx_data !== mon_exp) begin
               n_bad++;
               $display("FAIL rx_byte: got %02h, required %02h", rx_data, mon_exp);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic line_bit(input logic v, input int len);
      uart_rx = v;
      repeat (len) @(negedge sys_clk);
   endtask

   // Reference model: a good frame is buffered unless DEPTH bytes are already waiting.
   task automatic send_byte(input logic [7:0] b, input int bp, input bit stop_ok);
      if (stop_ok) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else                      exp_ovr = 1'b1;
      end else begin
         exp_fe = 1'b1;
      end
      line_bit(1'b0, bp);
      for (int i = 0; i < 8; i++) line_bit(b[i], bp);
      line_bit(stop_ok, bp);
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge sys_clk);
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge sys_clk);
      err_clr = 1'b0;
      exp_ovr = 1'b0;
      exp_fe  = 1'b0;
      @(negedge sys_clk);
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_frame_err"}, frame_err, exp_fe);
      check({tag, "_overrun"}, overrun, exp_ovr);
   endtask

   initial begin
      int n0;
      int bp;
      logic [7:0] b;

      repeat (3) @(negedge sys_clk);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_data_wr", rx_data_wr, 1'b0);
      check("reset_fifo_level", fifo_level, 0);
      check_flags("reset");
      rst_n = 1'b1;
      repeat (20) @(negedge sys_clk);

      // Single byte
      rx_ready = 1'b1;
      send_byte(8'hA5, BP, 1'b1);
      drain("single_drain", 100);
      check("single_level", fifo_level, 0);
      check("single_count", wr_times.size(), 1);
      check_flags("single");

      // Loader sequence, back-to-back frames
      wr_times.delete();
      send_byte(8'h7F, BP, 1'b1);
      send_byte(8'hFF, BP, 1'b1);
      drain("loader_drain", 100);
      check("loader_count", wr_times.size(), 2);
      if (wr_times.size() == 2)
         check("loader_gap_ge_2400", (wr_times[1] - wr_times[0]) >= 2400, 1'b1);

      // Backpressure and overrun
      rx_ready = 1'b0;
      for (int i = 1; i <= 9; i++) send_byte(8'(i), BP, 1'b1);
      check("bp_level", fifo_level, exp_q.size());
      check_flags("bp");
      wr_times.delete();
      rx_ready = 1'b1;
      drain("bp_drain", 50);
      check("bp_pulses", wr_times.size(), DEPTH);
      if (wr_times.size() == DEPTH)
         check("bp_consecutive", wr_times[DEPTH-1] - wr_times[0], DEPTH - 1);
      check("bp_level_after", fifo_level, 0);
      pulse_clr();
      check_flags("bp_clr");

      // Framing error, line held low, then a good byte
      send_byte(8'h55, BP, 1'b0);
      line_bit(1'b0, 5 * BP);
      line_bit(1'b1, BP);
      check_flags("fe");
      send_byte(8'h3C, BP, 1'b1);
      drain("fe_drain", 100);
      check_flags("fe_after");
      pulse_clr();
      check_flags("fe_clr");

      // Glitch rejection, then timing tolerance
      n0 = wr_times.size();
      line_bit(1'b0, 60);
      line_bit(1'b1, 2 * BP);
      check("glitch_no_pulse", wr_times.size(), n0);
      check("glitch_level", fifo_level, 0);
      check_flags("glitch");
      send_byte(8'hC3, BP - 7, 1'b1);
      drain("slow_fast_drain1", 100);
      line_bit(1'b1, 50);
      send_byte(8'hC3, BP + 7, 1'b1);
      drain("slow_fast_drain2", 100);
      check_flags("tol");

      // Random bytes, random bit period within tolerance, random idle gaps
      for (int i = 0; i < 6; i++) begin
         b  = 8'($urandom);
         bp = $urandom_range(233, 247);
         send_byte(b, bp, 1'b1);
         line_bit(1'b1, $urandom_range(0, 300));
      end
      drain("random_drain", 100);
      check_flags("random");

      // Asynchronous reset mid data bit with bytes buffered
      rx_ready = 1'b0;
      send_byte(8'h11, BP, 1'b1);
      send_byte(8'h22, BP, 1'b1);
      send_byte(8'h33, BP, 1'b1);
      check("rst_pre_level", fifo_level, 3);
      uart_rx = 1'b0;
      repeat (BP * 2 + BP / 2) @(negedge sys_clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_data_wr", rx_data_wr, 1'b0);
      check("rst_fifo_level", fifo_level, 0);
      exp_q.delete();
      exp_ovr = 1'b0;
      exp_fe  = 1'b0;
      check_flags("rst");
      uart_rx = 1'b1;
      repeat (5) @(negedge sys_clk);
      rst_n = 1'b1;
      rx_ready = 1'b1;
      repeat (BP) @(negedge sys_clk);
      send_byte(8'h42, BP, 1'b1);
      drain("rst_after_drain", 100);
      check("rst_after_level", fifo_level, 0);
      check_flags("rst_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
